instruction_assembler: RTL and testbench

INSTRUCTION_ASSEMBLER -- requirements
Module: instruction_assembler

---
 rtl/instruction_assembler.sv | 124 ++++++++++++
 tb/tb_instruction_assembler.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/instruction_assembler.sv
// instruction_assembler: packs variable-length byte streams into whole instructions and queues them in a FIFO.
module instruction_assembler #(
  parameter int BYTE_W    = 8,
  parameter int MAX_BYTES = 4,
  parameter int DEPTH     = 4
) (
  input  logic                              i_clk,
  input  logic                              i_reset_n,
  input  logic                              i_wr,
  input  logic [BYTE_W-1:0]                 i_data,
  input  logic                              i_flush,
  output logic                              o_in_ready,
  output logic                              o_ack,
  output logic [MAX_BYTES*BYTE_W-1:0]       o_instruction,
  output logic [$clog2(MAX_BYTES)-1:0]      o_len,
  output logic                              o_valid,
  input  logic                              i_rd,
  output logic [$clog2(DEPTH):0]            o_count,
  output logic                              o_err
);
  localparam int LW = $clog2(MAX_BYTES);
  localparam int IW = MAX_BYTES * BYTE_W;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {OPCODE, ARGS} state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   rem_q, rem_d, idx_q, idx_d, push_len;
  logic [IW-1:0]   asm_q, asm_d, push_data;
  logic            push, accept, pop, full;
  logic [IW-1:0]   mem_ins [DEPTH];
  logic [LW-1:0]   mem_len [DEPTH];
  logic [PW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   cnt_q;
  logic            ack_q, err_q;

  assign full          = cnt_q == CW'(DEPTH);
  assign o_in_ready    = !full && !i_flush;
  assign accept        = i_wr && o_in_ready;
  assign o_valid       = cnt_q != '0;
  assign pop           = i_rd && o_valid && !i_flush;
  assign o_instruction = o_valid ? mem_ins[rd_q] : '0;
  assign o_len         = o_valid ? mem_len[rd_q] : '0;
  assign o_count       = cnt_q;
  assign o_ack         = ack_q;
  assign o_err         = err_q;

  // idx_q is the next lane to fill; on the final byte it also equals length minus one
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    asm_d     = asm_q;
    push      = 1'b0;
    push_data = '0;
    push_len  = '0;
    if (i_flush) begin
      state_d = OPCODE;
      rem_d   = '0;
      idx_d   = '0;
      asm_d   = '0;
    end else if (accept && state_q == OPCODE) begin
      asm_d     = IW'(i_data);
      rem_d     = i_data[BYTE_W-1 -: LW];
      idx_d     = LW'(1);
      push_data = asm_d;
      push      = rem_d == '0;
      state_d   = rem_d == '0 ? OPCODE : ARGS;
    end else if (accept) begin
      asm_d[int'(idx_q)*BYTE_W +: BYTE_W] = i_data;
      rem_d     = rem_q - LW'(1);
      idx_d     = idx_q + LW'(1);
      push      = rem_q == LW'(1);
      push_data = asm_d;
      push_len  = idx_q;
      state_d   = rem_q == LW'(1) ? OPCODE : ARGS;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= OPCODE;
      rem_q   <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_ins[i] <= '0;
        mem_len[i] <= '0;
      end
    end else if (i_flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= accept;
      if (push) begin
        mem_ins[wr_q] <= push_data;
        mem_len[wr_q] <= push_len;
        wr_q          <= wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (i_rd && !o_valid) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instruction_assembler.sv
// tb_instruction_assembler: randomized and directed stimulus against a byte-queue reference model with a decoupled scoreboard.
module tb_instruction_assembler;
  localparam int BW = 8;
  localparam int MB = 4;
  localparam int D  = 4;
  localparam int LW = 2;
  localparam int IW = MB * BW;

  typedef struct {
    logic [IW-1:0] ins;
    logic [LW-1:0] len;
  } entry_t;

  logic          clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_wr = 1'b0, i_flush = 1'b0, i_rd = 1'b0;
  logic [BW-1:0] i_data = '0;
  logic          o_in_ready, o_ack, o_valid, o_err;
  logic [IW-1:0] o_instruction;
  logic [LW-1:0] o_len;
  logic [2:0]    o_count;

  instruction_assembler #(.BYTE_W(BW), .MAX_BYTES(MB), .DEPTH(D)) dut (
    .i_clk(clk), .i_reset_n(i_reset_n), .i_wr(i_wr), .i_data(i_data), .i_flush(i_flush),
    .o_in_ready(o_in_ready), .o_ack(o_ack), .o_instruction(o_instruction), .o_len(o_len),
    .o_valid(o_valid), .i_rd(i_rd), .o_count(o_count), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit started = 0;
  entry_t exp_q[$];
  logic [BW-1:0] part[$];
  int mcnt = 0, m_cnt = 0;
  bit merr = 0, m_err = 0, prev_acc = 0, m_ack = 0, m_rdy = 1;

  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) if (started && i_reset_n) begin
    check("count", 64'(o_count), 64'(m_cnt));
    check("valid", 64'(o_valid), 64'(m_cnt != 0));
    check("err", 64'(o_err), 64'(m_err));
    check("in_ready", 64'(o_in_ready), 64'(m_rdy));
    check("ack", 64'(o_ack), 64'(m_ack));
    if (!o_valid) begin
      check("instr_idle", 64'(o_instruction), 64'd0);
      check("len_idle", 64'(o_len), 64'd0);
    end else if (!i_flush) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL head got=%0h want=<none> t=%0t", o_instruction, $time);
      end else begin
        check("head_instr", 64'(o_instruction), 64'(exp_q[0].ins));
        check("head_len", 64'(o_len), 64'(exp_q[0].len));
        if (i_rd) void'(exp_q.pop_front());
      end
    end
  end

  // Model: collect raw bytes until the opcode's declared length is reached, then pack lanes.
  task automatic model_byte(input logic [BW-1:0] b, output bit pushed);
    int need;
    entry_t e;
    pushed = 0;
    part.push_back(b);
    need = int'(part[0] >> (BW - LW)) + 1;
    if (part.size() == need) begin
      e.ins = '0;
      foreach (part[k]) e.ins = e.ins | (IW'(part[k]) << (k * BW));
      e.len = LW'(need - 1);
      exp_q.push_back(e);
      part.delete();
      pushed = 1;
    end
  endtask

  task automatic step(input bit wr, input logic [BW-1:0] d, input bit rd, input bit fl);
    bit acc, pushed, popped;
    @(posedge clk);
    #2;
    m_ack = prev_acc;
    m_cnt = mcnt;
    m_err = merr;
    m_rdy = (mcnt < D) && !fl;
    i_wr = wr; i_data = d; i_rd = rd; i_flush = fl;
    acc = 0; pushed = 0; popped = 0;
    if (fl) begin
      mcnt = 0; merr = 0;
      part.delete();
      exp_q.delete();
    end else begin
      acc = wr && (mcnt < D);
      popped = rd && (mcnt > 0);
      if (rd && mcnt == 0) merr = 1;
      if (acc) model_byte(d, pushed);
      mcnt = mcnt + int'(pushed) - int'(popped);
    end
    prev_acc = acc;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    i_wr = 0; i_rd = 0; i_flush = 0;
    i_reset_n = 0;
    #1;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_count", 64'(o_count), 64'd0);
    check("rst_ack", 64'(o_ack), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    check("rst_instr", 64'(o_instruction), 64'd0);
    #1;
    i_reset_n = 1;
    mcnt = 0; merr = 0; prev_acc = 0;
    m_cnt = 0; m_err = 0; m_ack = 0; m_rdy = 1;
    part.delete();
    exp_q.delete();
    started = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, 0);
  endtask

  initial begin
    do_reset();
    step(1, 8'h05, 0, 0); idle(1); step(0, '0, 1, 0); idle(1);
    step(1, 8'hC1, 0, 0); idle(2); step(1, 8'hAA, 0, 0); idle(1);
    step(1, 8'hBB, 0, 0); idle(3); step(1, 8'hCC, 0, 0); idle(2);
    step(0, '0, 1, 0); idle(1);
    step(1, 8'h40, 0, 0); step(1, 8'h11, 0, 0);
    step(1, 8'h80, 0, 0); step(1, 8'h22, 0, 0); step(1, 8'h33, 0, 0); idle(1);
    step(0, '0, 1, 0); step(0, '0, 1, 0); idle(1);
    for (int i = 0; i < D; i++) step(1, 8'(i + 1), 0, 0);
    idle(1); step(1, 8'h09, 0, 0); idle(1);
    step(0, '0, 1, 0); idle(1); step(0, '0, 1, 0); step(0, '0, 1, 0); step(0, '0, 1, 0); step(0, '0, 1, 0);
    idle(1); step(0, '0, 1, 0); idle(1); step(0, '0, 0, 1); idle(1);
    step(1, 8'hC1, 0, 0); step(1, 8'hAA, 0, 0); do_reset();
    step(1, 8'h07, 0, 0); idle(1); step(0, '0, 1, 0); idle(1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      else step($urandom_range(0, 99) < 60, 8'($urandom_range(0, 255)),
                $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 2);
    end
    idle(2);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
